// File: rtl/u712_ram_sched_if.sv
// Request/grant and SDRAM command bundle between the U712 chip RAM scheduler
// and its neighbours (request decode on one side, cycle sequencer on the other).
interface u712_ram_sched_if;
  logic       dma_req;
  logic       cpu_req;
  logic       cycle_done;
  logic       dma_gnt;
  logic       cpu_gnt;
  logic [1:0] cmd;
  logic       init_done;
  logic       ref_busy;
  logic       ref_err;

  modport master (
    input  dma_req, cpu_req, cycle_done,
    output dma_gnt, cpu_gnt, cmd, init_done, ref_busy, ref_err
  );

  modport slave (
    output dma_req, cpu_req, cycle_done,
    input  dma_gnt, cpu_gnt, cmd, init_done, ref_busy, ref_err
  );
endinterface

// File: rtl/u712_ram_sched.sv
// Chip RAM scheduler: SDRAM power-up init, periodic auto-refresh bookkeeping,
// and fixed-priority arbitration of the single command path between DMA and CPU.
module u712_ram_sched #(
  parameter int INIT_WAIT    = 16000,
  parameter int REF_INTERVAL = 624,
  parameter int T_RP         = 2,
  parameter int T_RC         = 6,
  parameter int T_MRD        = 2
) (
  input  logic CLK80,
  input  logic RESET,
  u712_ram_sched_if.master bus
);

  localparam int DW = $clog2(INIT_WAIT + 1);
  localparam int RW = $clog2(REF_INTERVAL + 1);

  localparam logic [1:0] C_NOP = 2'b00;
  localparam logic [1:0] C_PRE = 2'b01;
  localparam logic [1:0] C_REF = 2'b10;
  localparam logic [1:0] C_LMR = 2'b11;

  typedef enum logic [3:0] {
    S_WAIT, S_I_PRE, S_I_REF1, S_I_REF2, S_I_MRS,
    S_IDLE, S_DMA, S_CPU, S_REFRESH
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] dly, dly_nx;
  logic [RW-1:0] rtmr;
  logic [1:0]    pend;
  logic [1:0]    cmd_nx;
  logic          rf_enter;
  logic          tick;
  logic          dma_gnt, cpu_gnt, init_done, ref_busy, ref_err;
  logic [1:0]    cmd;

  assign tick = init_done && (rtmr == RW'(REF_INTERVAL - 1));

  always_comb begin
    state_nx = state;
    dly_nx   = (dly == '0) ? '0 : dly - 1'b1;
    cmd_nx   = C_NOP;
    rf_enter = 1'b0;
    case (state)
      S_WAIT:   if (dly == '0) begin
                  state_nx = S_I_PRE;  cmd_nx = C_PRE; dly_nx = DW'(T_RP - 1);
                end
      S_I_PRE:  if (dly == '0) begin
                  state_nx = S_I_REF1; cmd_nx = C_REF; dly_nx = DW'(T_RC - 1);
                end
      S_I_REF1: if (dly == '0) begin
                  state_nx = S_I_REF2; cmd_nx = C_REF; dly_nx = DW'(T_RC - 1);
                end
      S_I_REF2: if (dly == '0) begin
                  state_nx = S_I_MRS;  cmd_nx = C_LMR; dly_nx = DW'(T_MRD - 1);
                end
      S_I_MRS:  if (dly == '0) state_nx = S_IDLE;
      // A backlog of two refreshes outranks DMA; a single one only outranks CPU.
      S_IDLE: begin
        if (pend >= 2'd2 || (!bus.dma_req && pend != 2'd0)) begin
          state_nx = S_REFRESH; cmd_nx = C_REF; dly_nx = DW'(T_RC - 1);
          rf_enter = 1'b1;
        end else if (bus.dma_req) begin
          state_nx = S_DMA;
        end else if (bus.cpu_req) begin
          state_nx = S_CPU;
        end
      end
      S_DMA, S_CPU: if (bus.cycle_done) state_nx = S_IDLE;
      S_REFRESH:    if (dly == '0) state_nx = S_IDLE;
      default:      state_nx = S_WAIT;
    endcase
  end

  always_ff @(posedge CLK80 or posedge RESET) begin
    if (RESET) begin
      state     <= S_WAIT;
      dly       <= DW'(INIT_WAIT - 1);
      cmd       <= C_NOP;
      dma_gnt   <= 1'b0;
      cpu_gnt   <= 1'b0;
      ref_busy  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nx;
      dly       <= dly_nx;
      cmd       <= cmd_nx;
      dma_gnt   <= (state_nx == S_DMA);
      cpu_gnt   <= (state_nx == S_CPU);
      ref_busy  <= (state_nx == S_REFRESH);
      init_done <= init_done | (state_nx == S_IDLE);
    end
  end

  always_ff @(posedge CLK80 or posedge RESET) begin
    if (RESET) begin
      rtmr    <= '0;
      pend    <= 2'd0;
      ref_err <= 1'b0;
    end else begin
      if (init_done) rtmr <= tick ? '0 : rtmr + 1'b1;
      // A tick coinciding with a refresh entry cancels out and cannot overflow.
      case ({tick, rf_enter})
        2'b10: if (pend == 2'd3) ref_err <= 1'b1;
               else              pend    <= pend + 2'd1;
        2'b01: pend <= pend - 2'd1;
        default: ;
      endcase
    end
  end

  assign bus.dma_gnt   = dma_gnt;
  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.cmd       = cmd;
  assign bus.init_done = init_done;
  assign bus.ref_busy  = ref_busy;
  assign bus.ref_err   = ref_err;

endmodule

// File: tb/tb_u712_ram_sched.sv
// Directed bench for u712_ram_sched: init timing, arbitration, refresh
// priority/urgency, overrun and asynchronous reset, with small timing parameters.
module tb_u712_ram_sched;

  localparam int INIT_WAIT    = 20;
  localparam int REF_INTERVAL = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  u712_ram_sched_if bus();

  u712_ram_sched #(
    .INIT_WAIT(INIT_WAIT), .REF_INTERVAL(REF_INTERVAL),
    .T_RP(2), .T_RC(6), .T_MRD(2)
  ) dut (
    .CLK80(clk),
    .RESET(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Per-cycle vector: inputs applied before an edge, outputs expected after it.
  typedef struct {
    int         reps;
    logic       d, c, done;
    logic [5:0] exp;   // {dma_gnt, cpu_gnt, cmd[1:0], ref_busy, ref_err}
  } vec_t;

  vec_t vt[$];

  task automatic add(input int reps, input logic d, input logic c, input logic done,
                     input logic eg, input logic ec, input logic [1:0] cmd,
                     input logic busy, input logic err);
    vec_t v;
    v.reps = reps; v.d = d; v.c = c; v.done = done;
    v.exp  = {eg, ec, cmd, busy, err};
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Init from reset release with both requests held: strobes at 20/22/28/34,
  // INIT_DONE at 36, first DMA grant at 37, nothing else in between.
  task automatic run_init(input string tag);
    logic [1:0] ec;
    logic [6:0] a, e;
    bus.dma_req = 1'b1; bus.cpu_req = 1'b1; bus.cycle_done = 1'b0;
    for (int k = 1; k <= 37; k++) begin
      @(posedge clk); #1;
      ec = (k == 20) ? 2'b01 : (k == 22 || k == 28) ? 2'b10 : (k == 34) ? 2'b11 : 2'b00;
      e  = {k >= 36, k == 37, 1'b0, ec, 1'b0, 1'b0};
      a  = {bus.init_done, bus.dma_gnt, bus.cpu_gnt, bus.cmd, bus.ref_busy, bus.ref_err};
      chk($sformatf("%s cyc%0d {init,dgnt,cgnt,cmd,busy,err}", tag, k), a, e);
    end
  endtask

  initial begin
    bus.dma_req = 1'b0; bus.cpu_req = 1'b0; bus.cycle_done = 1'b0;

    // Vectors start at edge 38 (DMA granted at 37); refresh ticks land at 76, 116, 156, ...
    add(1,  1,1,1, 0,0,2'b00,0,0);  // release DMA
    add(1,  0,1,0, 0,1,2'b00,0,0);  // CPU after one-cycle gap
    add(1,  0,1,1, 0,0,2'b00,0,0);
    add(1,  1,1,0, 1,0,2'b00,0,0);  // simultaneous: DMA wins
    add(1,  0,1,1, 0,0,2'b00,0,0);
    add(1,  0,1,0, 0,1,2'b00,0,0);  // CPU two cycles after done
    add(1,  0,0,1, 0,0,2'b00,0,0);
    add(32, 0,0,0, 0,0,2'b00,0,0);  // idle through first tick (PEND=1)
    add(1,  1,1,0, 1,0,2'b00,0,0);  // PEND=1: DMA still first
    add(1,  0,1,1, 0,0,2'b00,0,0);
    add(1,  0,1,0, 0,0,2'b10,1,0);  // refresh beats CPU
    add(5,  0,1,1, 0,0,2'b00,1,0);  // done ignored during refresh
    add(1,  0,1,0, 0,0,2'b00,0,0);
    add(1,  0,1,0, 0,1,2'b00,0,0);
    add(70, 0,1,0, 0,1,2'b00,0,0);  // hold CPU across two ticks
    add(1,  0,1,1, 0,0,2'b00,0,0);
    add(1,  0,1,0, 0,0,2'b10,1,0);  // first refresh (PEND=2)
    add(5,  0,1,0, 0,0,2'b00,1,0);
    add(1,  0,1,0, 0,0,2'b00,0,0);
    add(1,  0,1,0, 0,0,2'b10,1,0);  // second refresh (PEND=1)
    add(5,  0,1,0, 0,0,2'b00,1,0);
    add(1,  0,1,0, 0,0,2'b00,0,0);
    add(1,  0,1,0, 0,1,2'b00,0,0);  // CPU finally serviced
    add(143,0,1,0, 0,1,2'b00,0,0);  // ticks 196/236/276 saturate PEND
    add(7,  0,1,0, 0,1,2'b00,0,1);  // tick 316 overruns

    #2;
    chk("reset {dgnt,cgnt,cmd,busy,err,init}",
        {bus.dma_gnt, bus.cpu_gnt, bus.cmd, bus.ref_busy, bus.ref_err, bus.init_done}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_init("init1");

    for (int i = 0; i < vt.size(); i++) begin
      for (int r = 0; r < vt[i].reps; r++) begin
        bus.dma_req = vt[i].d; bus.cpu_req = vt[i].c; bus.cycle_done = vt[i].done;
        @(posedge clk); #1;
        chk($sformatf("vec%0d.%0d {dgnt,cgnt,cmd,busy,err}", i, r),
            {bus.dma_gnt, bus.cpu_gnt, bus.cmd, bus.ref_busy, bus.ref_err}, vt[i].exp);
      end
    end

    // Asynchronous reset mid-grant, between clock edges.
    bus.cycle_done = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("midreset cpu_gnt",   bus.cpu_gnt,   0);
    chk("midreset init_done", bus.init_done, 0);
    chk("midreset ref_err",   bus.ref_err,   0);
    chk("midreset cmd",       bus.cmd,       0);
    @(posedge clk); #1 rst = 1'b0;

    run_init("init2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
